// File: rtl/dual_rail_collector.sv
// Collects an 8-pair dual-rail word, decodes it to b_out/a_out and runs the
// four-phase ack handshake with the sender, the valid/ready hand-off to the consumer, and timeout/illegal-code recovery.
module dual_rail_collector #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d_0,
  input  logic [7:0] d_1,
  input  logic       ready,
  output logic       ack,
  output logic [3:0] b_out,
  output logic [3:0] a_out,
  output logic       valid,
  output logic       err_illegal,
  output logic       err_timeout,
  output logic [7:0] word_cnt
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_SPACER, S_DATA, S_OUT, S_RTZ} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    r0_reg, r1_reg;
  logic [CW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [3:0]    b_out_reg, a_out_reg;
  logic [7:0]    word_cnt_reg;
  logic          err_ill_reg, err_ill_next;
  logic          err_tmo_reg, err_tmo_next;
  logic          capture, accept;

  logic [7:0] pair_null, pair_data, pair_ill;
  logic       spacer, complete, illegal, partial;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pair
      assign pair_null[gi] = ~r0_reg[gi] & ~r1_reg[gi];
      assign pair_data[gi] = r0_reg[gi] ^ r1_reg[gi];
      assign pair_ill[gi]  = r0_reg[gi] & r1_reg[gi];
    end
  endgenerate

  assign spacer   = &pair_null;
  assign complete = &pair_data;
  assign illegal  = |pair_ill;
  assign partial  = ~spacer & ~complete & ~illegal;

  always_comb begin
    state_next   = state_reg;
    tmo_cnt_next = '0;
    capture      = 1'b0;
    accept       = 1'b0;
    err_ill_next = 1'b0;
    err_tmo_next = 1'b0;
    case (state_reg)
      S_SPACER: if (spacer) state_next = S_DATA;
      S_DATA: begin
        if (illegal) begin
          err_ill_next = 1'b1;
          state_next   = S_SPACER;
        end else if (complete) begin
          capture    = 1'b1;
          state_next = S_OUT;
        end else if (partial) begin
          // Illegal is tested first, so a simultaneous timeout is suppressed.
          if (tmo_cnt_reg == TMO_LAST) begin
            err_tmo_next = 1'b1;
            state_next   = S_SPACER;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + CW'(1);
          end
        end
      end
      // Rails are deliberately ignored here: ack stays high until the consumer takes the word.
      S_OUT: if (ready) begin
        accept     = 1'b1;
        state_next = S_RTZ;
      end
      S_RTZ: begin
        if (illegal) begin
          err_ill_next = 1'b1;
          state_next   = S_SPACER;
        end else if (spacer) begin
          state_next = S_DATA;
        end
      end
      default: state_next = S_SPACER;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_SPACER;
      r0_reg       <= '0;
      r1_reg       <= '0;
      tmo_cnt_reg  <= '0;
      b_out_reg    <= '0;
      a_out_reg    <= '0;
      word_cnt_reg <= '0;
      err_ill_reg  <= 1'b0;
      err_tmo_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      r0_reg      <= d_0;
      r1_reg      <= d_1;
      tmo_cnt_reg <= tmo_cnt_next;
      err_ill_reg <= err_ill_next;
      err_tmo_reg <= err_tmo_next;
      if (capture) begin
        b_out_reg <= r1_reg[7:4];
        a_out_reg <= r1_reg[3:0];
      end
      if (accept) word_cnt_reg <= word_cnt_reg + 8'd1;
    end
  end

  assign ack         = (state_reg == S_OUT) || (state_reg == S_RTZ);
  assign valid       = (state_reg == S_OUT);
  assign b_out       = b_out_reg;
  assign a_out       = a_out_reg;
  assign err_illegal = err_ill_reg;
  assign err_timeout = err_tmo_reg;
  assign word_cnt    = word_cnt_reg;

endmodule

// File: tb/tb_dual_rail_collector.sv
// Bench for dual_rail_collector: two instances (TIMEOUT 255 and 4) share stimulus;
// a flag-based behavioural model is compared every cycle, plus directed literal checks.
module tb_dual_rail_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d_0 = 8'h00;
  logic [7:0] d_1 = 8'h00;
  logic       ready = 1'b1;

  logic       ack_o[2], valid_o[2], eill_o[2], etmo_o[2];
  logic [3:0] b_o[2], a_o[2];
  logic [7:0] cnt_o[2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dual_rail_collector #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .d_0(d_0), .d_1(d_1), .ready(ready),
    .ack(ack_o[0]), .b_out(b_o[0]), .a_out(a_o[0]), .valid(valid_o[0]),
    .err_illegal(eill_o[0]), .err_timeout(etmo_o[0]), .word_cnt(cnt_o[0])
  );

  dual_rail_collector #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .d_0(d_0), .d_1(d_1), .ready(ready),
    .ack(ack_o[1]), .b_out(b_o[1]), .a_out(a_o[1]), .valid(valid_o[1]),
    .err_illegal(eill_o[1]), .err_timeout(etmo_o[1]), .word_cnt(cnt_o[1])
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Behavioural model: per instance, flags describe where the handshake stands.
  logic [7:0] m_r0[2], m_r1[2];
  bit         m_hold[2], m_rtz[2], m_armed[2], m_eill[2], m_etmo[2];
  int         m_age[2];
  logic [3:0] m_b[2], m_a[2];
  logic [7:0] m_cnt[2];

  function automatic int tlim(input int k);
    return (k == 0) ? 255 : 4;
  endfunction

  task automatic model_reset(input int k);
    m_r0[k] = 8'h00; m_r1[k] = 8'h00;
    m_hold[k] = 0; m_rtz[k] = 0; m_armed[k] = 0;
    m_eill[k] = 0; m_etmo[k] = 0; m_age[k] = 0;
    m_b[k] = 4'h0; m_a[k] = 4'h0; m_cnt[k] = 8'h00;
  endtask

  task automatic model_step(input int k);
    int nn = 0, nd = 0, ni = 0;
    logic [7:0] w;
    for (int p = 0; p < 8; p++) begin
      case ({m_r0[k][p], m_r1[k][p]})
        2'b00:   nn++;
        2'b11:   ni++;
        default: nd++;
      endcase
    end
    m_eill[k] = 0;
    m_etmo[k] = 0;
    if (m_hold[k]) begin
      if (ready) begin
        m_hold[k] = 0; m_rtz[k] = 1; m_cnt[k] = m_cnt[k] + 8'd1;
      end
    end else if (m_rtz[k]) begin
      if (ni > 0) begin
        m_eill[k] = 1; m_rtz[k] = 0;
      end else if (nn == 8) begin
        m_rtz[k] = 0; m_armed[k] = 1;
      end
    end else if (m_armed[k]) begin
      if (ni > 0) begin
        m_eill[k] = 1; m_armed[k] = 0; m_age[k] = 0;
      end else if (nd == 8) begin
        w = m_r1[k];
        m_b[k] = w[7:4]; m_a[k] = w[3:0];
        m_hold[k] = 1; m_armed[k] = 0; m_age[k] = 0;
      end else if (nn == 8) begin
        m_age[k] = 0;
      end else begin
        m_age[k]++;
        if (m_age[k] >= tlim(k)) begin
          m_etmo[k] = 1; m_armed[k] = 0; m_age[k] = 0;
        end
      end
    end else if (nn == 8) begin
      m_armed[k] = 1;
    end
    m_r0[k] = d_0;
    m_r1[k] = d_1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) model_reset(k);
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) model_reset(k);
        else model_step(k);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model ack[%0d]", k), ack_o[k], m_hold[k] || m_rtz[k]);
        chk($sformatf("model valid[%0d]", k), valid_o[k], m_hold[k]);
        chk($sformatf("model b_out[%0d]", k), b_o[k], m_b[k]);
        chk($sformatf("model a_out[%0d]", k), a_o[k], m_a[k]);
        chk($sformatf("model word_cnt[%0d]", k), cnt_o[k], m_cnt[k]);
        chk($sformatf("model err_illegal[%0d]", k), eill_o[k], m_eill[k]);
        chk($sformatf("model err_timeout[%0d]", k), etmo_o[k], m_etmo[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [7:0] z, input logic [7:0] o);
    d_0 = z;
    d_1 = o;
  endtask

  initial begin
    logic [7:0] val, mask;
    #1;
    chk("reset ack", ack_o[0], 0);
    chk("reset valid", valid_o[0], 0);
    chk("reset b_out", b_o[0], 0);
    chk("reset a_out", a_o[0], 0);
    chk("reset word_cnt", cnt_o[0], 0);
    chk("reset errs", {eill_o[0], etmo_o[0]}, 0);
    tick(); tick();
    rst = 1'b0;

    // Basic capture with ready high.
    tick();
    drive(8'h5A, 8'hA5);
    tick();
    chk("s1 valid early", valid_o[0], 0);
    tick();
    chk("s1 valid", valid_o[0], 1);
    chk("s1 ack", ack_o[0], 1);
    chk("s1 b_out", b_o[0], 4'hA);
    chk("s1 a_out", a_o[0], 4'h5);
    drive(8'h00, 8'h00);
    tick();
    chk("s1 valid drop", valid_o[0], 0);
    chk("s1 ack held", ack_o[0], 1);
    chk("s1 word_cnt", cnt_o[0], 1);
    tick();
    chk("s1 ack drop", ack_o[0], 0);

    // One pair per cycle.
    val = 8'h3C;
    mask = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mask[i] = 1'b1;
      drive(~val & mask, val & mask);
      tick();
      chk("s2 no early capture", valid_o[0], 0);
    end
    tick();
    chk("s2 valid", valid_o[0], 1);
    chk("s2 b_out", b_o[0], 4'h3);
    chk("s2 a_out", a_o[0], 4'hC);
    chk("s2 no errors", {eill_o[0], etmo_o[0]}, 0);
    chk("s2 short timeout no capture", valid_o[1], 0);
    drive(8'h00, 8'h00);
    tick(); tick();

    // Illegal code, then data is refused until a spacer.
    drive(8'h01, 8'h01);
    tick(); tick();
    chk("s3 err_illegal", eill_o[0], 1);
    chk("s3 valid", valid_o[0], 0);
    drive(8'h0F, 8'hF0);
    tick();
    chk("s3 err_illegal pulse end", eill_o[0], 0);
    tick();
    chk("s3 refused before spacer", valid_o[0], 0);
    drive(8'h00, 8'h00);
    tick(); tick();
    drive(8'h0F, 8'hF0);
    tick(); tick();
    chk("s3 valid after spacer", valid_o[0], 1);
    chk("s3 b_out", b_o[0], 4'hF);
    chk("s3 a_out", a_o[0], 4'h0);
    drive(8'h00, 8'h00);
    tick(); tick();

    // Timeout on the TIMEOUT=4 instance.
    drive(8'h00, 8'h01);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("s4 err_timeout c%0d", k), etmo_o[1], (k == 5));
      chk($sformatf("s4 long timeout quiet c%0d", k), etmo_o[0], 0);
    end
    chk("s4 no capture", valid_o[1], 0);
    chk("s4 ack low", ack_o[1], 0);
    drive(8'h00, 8'h00);
    tick(); tick();

    // Illegal and timeout landing on the same cycle.
    drive(8'h00, 8'h01);
    tick(); tick(); tick();
    drive(8'h80, 8'h80);
    tick(); tick();
    chk("s5 err_illegal wins", eill_o[1], 1);
    chk("s5 err_timeout suppressed", etmo_o[1], 0);
    drive(8'h00, 8'h00);
    tick(); tick();

    // Consumer stalls with spacer (and an illegal burst) on the rails.
    ready = 1'b0;
    drive(8'h69, 8'h96);
    tick(); tick();
    chk("s6 valid", valid_o[0], 1);
    drive(8'h00, 8'h00);
    repeat (8) tick();
    drive(8'hFF, 8'hFF);
    repeat (3) tick();
    drive(8'h00, 8'h00);
    repeat (9) tick();
    chk("s6 valid held", valid_o[0], 1);
    chk("s6 ack held", ack_o[0], 1);
    chk("s6 b_out held", b_o[0], 4'h9);
    chk("s6 a_out held", a_o[0], 4'h6);
    chk("s6 illegal ignored", eill_o[0], 0);
    ready = 1'b1;
    tick();
    chk("s6 valid drop", valid_o[0], 0);
    chk("s6 ack still high", ack_o[0], 1);
    tick();
    chk("s6 ack drop", ack_o[0], 0);
    chk("s6 word_cnt", cnt_o[0], 4);
    chk("s6 word_cnt short", cnt_o[1], 3);

    // Asynchronous reset while a word is pending.
    ready = 1'b0;
    drive(8'hF0, 8'h0F);
    tick(); tick();
    chk("s7 valid pending", valid_o[0], 1);
    rst = 1'b1;
    #1;
    chk("s7 async valid", valid_o[0], 0);
    chk("s7 async ack", ack_o[0], 0);
    chk("s7 async b_out", b_o[0], 0);
    chk("s7 async a_out", a_o[0], 0);
    chk("s7 async word_cnt", cnt_o[0], 0);
    drive(8'h00, 8'h00);
    tick();
    rst = 1'b0;
    ready = 1'b1;

    // 256 back-to-back words wrap the counter.
    for (int i = 0; i < 256; i++) begin
      val = i[7:0];
      drive(~val, val);
      tick(); tick();
      drive(8'h00, 8'h00);
      tick(); tick();
      if (i == 254) chk("s8 word_cnt 255", cnt_o[0], 8'd255);
    end
    chk("s8 word_cnt wrap", cnt_o[0], 0);
    chk("s8 word_cnt wrap short", cnt_o[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_rail_collector.md
DUAL_RAIL_COLLECTOR -- requirements
Module: dual_rail_collector

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 255, max clk cycles a partial (incomplete) dual-rail word may persist.
REQ-002 SHALL provide clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide d_0  input  8  false rails; bit map {b4,b3,b2,b1,a3,a2,a1,a0}_0 (bit7=b4 ... bit0=a0).
REQ-005 SHALL provide d_1  input  8  true rails; same bit map as d_0.
REQ-006 SHALL provide ack  output  1  four-phase acknowledge to the dual-rail sender.
REQ-007 SHALL provide b_out  output  4  decoded {b4,b3,b2,b1}.
REQ-008 SHALL provide a_out  output  4  decoded {a3,a2,a1,a0}.
REQ-009 SHALL provide valid  output  1  b_out/a_out hold a captured word.
REQ-010 SHALL provide ready  input  1  consumer accepts word when valid&ready at a rising edge.
REQ-011 SHALL provide err_illegal  output  1  one-cycle pulse, some pair sampled 11.
REQ-012 SHALL provide err_timeout  output  1  one-cycle pulse, partial word exceeded TIMEOUT.
REQ-013 SHALL provide word_cnt  output  8  count of accepted words, wraps 255->0.

Function
REQ-014 SHALL register d_0/d_1 in one input stage; all decisions below use the registered copy (r0,r1).
REQ-015 SHALL define per pair i: NULL = 00, DATA0 = 10 (r0=1), DATA1 = 01 (r1=1), ILLEGAL = 11.
REQ-016 SHALL define spacer = all 8 pairs NULL; complete = all 8 pairs DATA0/DATA1; partial = neither spacer nor complete, no ILLEGAL.
REQ-017 SHALL implement states S_SPACER, S_DATA, S_OUT, S_RTZ.
REQ-018 S_SPACER: ack=0; on spacer -> S_DATA; otherwise stay (flushes leftover data after reset/error).
REQ-019 S_DATA: ack=0; on complete -> capture b_out/a_out = r1 bits, valid=1, ack=1, -> S_OUT.
REQ-020 Latency: complete word on d_0/d_1 before edge N SHALL give valid=1 and ack=1 after edge N+1.
REQ-021 S_OUT: ack=1, valid=1, outputs stable; on valid&ready -> valid=0, word_cnt+1, -> S_RTZ.
REQ-022 S_RTZ: ack=1, valid=0; on spacer -> ack=0, -> S_DATA.
REQ-023 If S_OUT sees spacer before ready, SHALL stay in S_OUT (ack held 1); the sender waits regardless.
REQ-024 Timeout counter SHALL count cycles of partial in S_DATA; clear on spacer, complete, or state exit.
REQ-025 When counter reaches TIMEOUT: err_timeout=1 for one cycle, counter cleared, -> S_SPACER; no capture.
REQ-026 ILLEGAL in any pair in S_DATA or S_RTZ: err_illegal=1 for one cycle, -> S_SPACER, ack=0; captured data in S_OUT unaffected.
REQ-027 ILLEGAL during S_OUT SHALL be ignored until S_RTZ is entered.
REQ-028 Illegal and timeout in the same cycle: err_illegal only.
REQ-029 Pairs arriving in any order/cycles SHALL be accepted; only the all-complete cycle matters.

Reset
REQ-030 rst=1 SHALL immediately force S_SPACER, ack=0, valid=0, b_out=0, a_out=0, err_illegal=0, err_timeout=0, word_cnt=0, timeout counter=0, input register=0.
REQ-031 Reset mid-handshake SHALL drop a pending word (no word_cnt increment); after release the block waits for spacer.

Verification
REQ-032 Reset release, d_0=d_1=0, then d_1=8'hA5, d_0=8'h5A, ready=1 -> valid/ack high 2 edges later, b_out=4'hA, a_out=4'h5; word_cnt=1 after spacer.
REQ-033 Rails applied one pair per cycle over 8 cycles, TIMEOUT=255 -> single capture, no error, value matches.
REQ-034 d_0=d_1=8'h01 in S_DATA -> err_illegal one-cycle pulse, valid stays 0, new word accepted only after spacer.
REQ-035 TIMEOUT=4, one pair held partial for 10 cycles -> err_timeout pulse on 4th counted cycle, state S_SPACER, no capture.
REQ-036 ready=0 for 20 cycles with spacer returned -> valid, ack, outputs held; ready=1 -> valid drops next edge, ack drops next edge.
REQ-037 256 back-to-back words -> word_cnt wraps to 0; rst asserted while valid=1 -> all outputs 0 asynchronously.
